// File: rtl/weight_ram_loader_pkg.sv
// Shared definitions for the hidden-weight RAM loader: FSM state encoding,
// network geometry and the checksum helper used by both checksum paths.
package weight_load_pkg;

    localparam int INPUT_NODES         = 784;
    localparam int HIDDEN_NODES        = 32;
    localparam int HIDDEN_WEIGHT_WORDS = INPUT_NODES * HIDDEN_NODES;
    localparam int CSUM_W              = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DRAIN  = 3'd2,
        VERIFY = 3'd3,
        CHECK  = 3'd4,
        DONE   = 3'd5,
        ERROR  = 3'd6
    } state_e;

    // Additive checksum step; wraps silently at 2**CSUM_W.
    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [CSUM_W-1:0] val);
        return acc + val;
    endfunction

endpackage

// File: rtl/weight_ram_loader_if.sv
// Byte-stream input plus single-port weight RAM bus seen by the loader.
// master = loader side (drives the RAM, accepts the stream),
// slave  = environment side (byte source and RAM).
interface weight_ram_loader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    modport master (
        input  in_data, in_valid, ram_q,
        output in_ready, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output in_data, in_valid, ram_q,
        input  in_ready, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/weight_ram_loader_checksum_acc.sv
// 16-bit additive checksum accumulator; clear has priority over accumulate.
module checksum_acc
    import weight_load_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [CSUM_W-1:0] sum
);

    logic [CSUM_W-1:0] r_sum;

    // Running sum: cleared at the start of a load, stepped on each enabled byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (clr) begin
            r_sum <= '0;
        end else if (en) begin
            r_sum <= csum_add(r_sum, CSUM_W'(din));
        end
    end

    assign sum = r_sum;

endmodule

// File: rtl/weight_ram_loader.sv
// Hidden-weight RAM loader: streams NUM_WORDS bytes into the RAM from
// address 0, reads them all back and compares additive checksums.
module weight_ram_loader
    import weight_load_pkg::*;
#(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 8,
    parameter int NUM_WORDS = HIDDEN_WEIGHT_WORDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    weight_ram_loader_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W:0]     byte_cnt
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_LOAD   = LOAD;
    localparam logic [2:0] S_DRAIN  = DRAIN;
    localparam logic [2:0] S_VERIFY = VERIFY;
    localparam logic [2:0] S_CHECK  = CHECK;
    localparam logic [2:0] S_DONE   = DONE;
    localparam logic [2:0] S_ERROR  = ERROR;

    // Count of the final byte and address of the final read.
    localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    logic [2:0]        r_state;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [ADDR_W:0]   r_byte_cnt;
    logic              r_rd_vld;

    logic              w_in_ready;
    logic              w_xfer;
    logic              w_start_go;
    logic [CSUM_W-1:0] w_wsum;
    logic [CSUM_W-1:0] w_rsum;
    logic [CSUM_W-1:0] w_rsum_final;
    logic              w_sum_match;

    assign w_in_ready = (r_state == S_LOAD);
    // Abort takes priority, so a byte offered in the abort cycle is dropped.
    assign w_xfer     = w_in_ready && bus.in_valid && !abort;
    assign w_start_go = start && !abort &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));

    // The last read word arrives during CHECK; fold it in so the verdict
    // lands on the same edge that captures it into rsum.
    assign w_rsum_final = csum_add(w_rsum, CSUM_W'(bus.ram_q));
    assign w_sum_match  = (w_rsum_final == w_wsum);

    checksum_acc #(.DATA_W(DATA_W)) u_wsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_go),
        .en    (w_xfer),
        .din   (bus.in_data),
        .sum   (w_wsum)
    );

    checksum_acc #(.DATA_W(DATA_W)) u_rsum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_start_go),
        .en    (r_rd_vld),
        .din   (bus.ram_q),
        .sum   (w_rsum)
    );

    // Load/verify sequencer: state, RAM port registers and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_byte_cnt  <= '0;
            r_rd_vld    <= 1'b0;
        end else if (abort) begin
            // byte_cnt and the RAM address are left as-is for debug.
            r_state  <= S_IDLE;
            r_ram_we <= 1'b0;
            r_rd_vld <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            r_rd_vld <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_byte_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_ram_we    <= 1'b1;
                        r_ram_addr  <= r_byte_cnt[ADDR_W-1:0];
                        r_ram_wdata <= bus.in_data;
                        r_byte_cnt  <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == LAST_CNT) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final write is on the port this cycle; arm read pointer.
                    r_ram_addr <= '0;
                    r_state    <= S_VERIFY;
                end
                S_VERIFY: begin
                    r_rd_vld <= 1'b1;
                    if (r_ram_addr == LAST_ADDR) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_ram_addr <= r_ram_addr + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_state <= w_sum_match ? S_DONE : S_ERROR;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;

    assign busy     = (r_state == S_LOAD) || (r_state == S_DRAIN) ||
                      (r_state == S_VERIFY) || (r_state == S_CHECK);
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERROR);
    assign byte_cnt = r_byte_cnt;

endmodule
